// File: rtl/booth_pkg.sv
// Shared constants, FSM state type and the radix-16 Booth digit decode for the
// sequential 32x32 signed multiplier.
package booth_pkg;

  localparam int WIDTH     = 32;
  localparam int STEPS     = WIDTH / 4;
  localparam int WIN_BITS  = 5;
  localparam int STEP_BITS = 3;
  localparam int PROD_BITS = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Window {y4..y0} -> -8*y4 + 4*y3 + 2*y2 + y1 + y0, range -8..+8.
  function automatic logic signed [4:0] booth_digit(input logic [4:0] y);
    logic signed [5:0] t;
    t = 6'sd0
        - (y[4] ? 6'sd8 : 6'sd0)
        + (y[3] ? 6'sd4 : 6'sd0)
        + (y[2] ? 6'sd2 : 6'sd0)
        + (y[1] ? 6'sd1 : 6'sd0)
        + (y[0] ? 6'sd1 : 6'sd0);
    return t[4:0];
  endfunction

endpackage

// File: rtl/booth_window_shifter.sv
// Holds the 33-bit {B,0} multiplier register and the step counter; presents one
// overlapping 5-bit Booth window per cycle and flags the final step.
module booth_window_shifter
  import booth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [WIN_BITS-1:0]  y_win_o,
  output logic [STEP_BITS-1:0] step_o,
  output logic                 last_step_o
);

  logic [WIDTH:0]       mreg_q, mreg_d;
  logic [STEP_BITS-1:0] step_q, step_d;
  logic                 last_s;

  assign last_s = (step_q == 3'(STEPS - 1));

  // The register is zeroed after the last window so the encoder idles at 0
  // in IDLE and DONE without extra muxing on Y_win.
  always_comb begin
    mreg_d = mreg_q;
    step_d = step_q;
    if (load_i) begin
      mreg_d = {b_i, 1'b0};
      step_d = 3'd0;
    end else if (shift_i) begin
      if (last_s) begin
        mreg_d = '0;
        step_d = 3'd0;
      end else begin
        mreg_d = $signed(mreg_q) >>> 4;
        step_d = step_q + 3'd1;
      end
    end else begin
      mreg_d = mreg_q;
      step_d = step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mreg_q <= '0;
      step_q <= 3'd0;
    end else begin
      mreg_q <= mreg_d;
      step_q <= step_d;
    end
  end

  assign y_win_o     = mreg_q[WIN_BITS-1:0];
  assign step_o      = step_q;
  assign last_step_o = last_s;

endmodule

// File: rtl/booth_r16_seq_accumulator.sv
// Sequential radix-16 Booth multiplier core: feeds A and one Booth window per
// cycle to an external PP encoder and shift-accumulates the returned products.
module booth_r16_seq_accumulator
  import booth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [WIDTH-1:0]     X_op,
  output logic [WIN_BITS-1:0]  Y_win,
  input  logic [PROD_BITS-1:0] PP_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PROD_BITS-1:0] P
);

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     x_op_q;
  logic [PROD_BITS-1:0] acc_q;
  logic [PROD_BITS-1:0] p_q;

  logic                 load_s;
  logic                 shift_s;
  logic                 last_step_s;
  logic [STEP_BITS-1:0] step_s;
  logic [PROD_BITS-1:0] shifted_pp_s;
  logic [PROD_BITS-1:0] acc_sum_s;

  assign load_s  = (state_q == IDLE) && in_valid;
  assign shift_s = (state_q == RUN);

  booth_window_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_s),
    .shift_i     (shift_s),
    .b_i         (B),
    .y_win_o     (Y_win),
    .step_o      (step_s),
    .last_step_o (last_step_s)
  );

  // Bits shifted past bit 63 drop out; the accumulator wraps mod 2^64.
  assign shifted_pp_s = PP_in << {step_s, 2'b00};
  assign acc_sum_s    = acc_q + shifted_pp_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_op_q      <= '0;
      acc_q       <= '0;
      p_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_op_q     <= A;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_sum_s;
          if (last_step_s) begin
            p_q         <= acc_sum_s;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign X_op      = x_op_q;
  assign P         = p_q;

endmodule

// File: tb/tb_booth_r16_seq_accumulator.sv
// Directed bench for booth_r16_seq_accumulator with a behavioural PP encoder.
module tb_booth_r16_seq_accumulator;
  import booth_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic [31:0] X_op;
  logic [4:0]  Y_win;
  logic [63:0] PP_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] P;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_r16_seq_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .X_op(X_op), .Y_win(Y_win), .PP_in(PP_in),
    .out_valid(out_valid), .out_ready(out_ready), .P(P)
  );

  // External encoder: sext64(X_op) * digit(Y_win)
  logic signed [4:0] dig_s;
  assign dig_s = booth_digit(Y_win);
  assign PP_in = $signed({{32{X_op[31]}}, X_op}) * $signed({{59{dig_s[4]}}, dig_s});

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Window i straight from B's bit positions: {B[4i+3:4i], B[4i-1]}, B[-1]=0.
  function automatic logic [4:0] exp_win(input logic [31:0] b, input int i);
    logic [4:0] w;
    w[4:1] = b[4*i +: 4];
    w[0]   = (i == 0) ? 1'b0 : b[4*i-1];
    return w;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input int hold);
    logic [63:0] p_seen;
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    A = a; B = b; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    A = 32'hDEADBEEF; B = 32'h0BADF00D;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      chk($sformatf("y_win_step%0d", s), {59'd0, Y_win}, {59'd0, exp_win(b, s)});
      if (s == 0)
        chk("x_op", {32'd0, X_op}, {32'd0, a});
      if (s == 7) begin
        chk("in_ready_run", {63'd0, in_ready}, 64'd0);
        chk("out_valid_run", {63'd0, out_valid}, 64'd0);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("out_valid_done", {63'd0, out_valid}, 64'd1);
    chk("product", P, exp_p);
    chk("y_win_done", {59'd0, Y_win}, 64'd0);
    p_seen = P;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_p", P, p_seen);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_pulse_end", {63'd0, out_valid}, 64'd0);
    chk("in_ready_back", {63'd0, in_ready}, 64'd1);
    chk("p_kept", P, exp_p);
  endtask

  initial begin
    vecs[0]  = '{32'd3,        32'd5,        64'd15,                  0};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1,                   0};
    vecs[2]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001,    0};
    vecs[3]  = '{32'h80000000, 32'h80000000, 64'h4000000000000000,    0};
    vecs[4]  = '{32'h12345678, 32'hFFFFFFF9, 64'hFFFFFFFF8091A2B8,    5};
    vecs[5]  = '{32'd0,        32'h5A5A5A5A, 64'd0,                   0};
    vecs[6]  = '{32'd1,        32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,    0};
    vecs[7]  = '{32'h80000000, 32'd1,        64'hFFFFFFFF80000000,    0};
    vecs[8]  = '{32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000,    1};
    vecs[9]  = '{32'h00010000, 32'h00010000, 64'h0000000100000000,    0};
    vecs[10] = '{32'd9,        32'd9,        64'd81,                  0};
    vecs[11] = '{32'h88888888, 32'd1,        64'hFFFFFFFF88888888,    0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_p", P, 64'd0);
    chk("rst_x_op", {32'd0, X_op}, 64'd0);
    chk("rst_y_win", {59'd0, Y_win}, 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 12; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].hold);

    // Abort 9*9 at step 4 with a synchronous reset.
    @(negedge clk);
    A = 32'd9; B = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_in_run", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_p", P, 64'd0);
    chk("abort_y_win", {59'd0, Y_win}, 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("abort_no_valid", {63'd0, seen}, 64'd0);
    end
    run_op(32'hFFFFFFFC, 32'd6, 64'hFFFFFFFFFFFFFFE8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
